// File: rtl/ab_and_monitor.sv
// Concurrent-assertion style monitor for (a AND b): arms after reset/enable,
// then scores every enabled cycle into pulses, saturating counters, a sticky error and a first-failure timestamp.
module ab_and_monitor #(
  parameter int CNT_W        = 16,
  parameter int TS_W         = 32,
  parameter int ARM_CYC      = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [TS_W-1:0]  first_fail_ts,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [7:0]       ARM_LOAD = 8'(ARM_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [TS_W-1:0]  TS_ONE   = 1;

  state_t             state_q, state_d;
  logic [7:0]         arm_cnt_q, arm_cnt_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic               err_q, err_d;
  logic [TS_W-1:0]    first_fail_ts_q, first_fail_ts_d;
  logic               pass_pulse_q, pass_pulse_d;
  logic               fail_pulse_q, fail_pulse_d;
  logic               eval_pass, eval_fail;

  always_comb begin
    // A sample is scored only in CHECK with en high; clr discards it entirely.
    eval_pass       = (state_q == CHECK) && en && !clr && a && b;
    eval_fail       = (state_q == CHECK) && en && !clr && !(a && b);

    state_d         = state_q;
    arm_cnt_d       = arm_cnt_q;
    ts_d            = ts_q + TS_ONE;
    pass_cnt_d      = pass_cnt_q;
    fail_cnt_d      = fail_cnt_q;
    err_d           = err_q;
    first_fail_ts_d = first_fail_ts_q;
    pass_pulse_d    = eval_pass;
    fail_pulse_d    = eval_fail;

    if (eval_pass && (pass_cnt_q != CNT_MAX)) begin
      pass_cnt_d = pass_cnt_q + CNT_ONE;
    end
    if (eval_fail) begin
      if (fail_cnt_q != CNT_MAX) begin
        fail_cnt_d = fail_cnt_q + CNT_ONE;
      end
      err_d = 1'b1;
      if (!err_q) begin
        first_fail_ts_d = ts_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = (ARM_CYC == 0) ? CHECK : ARM;
          arm_cnt_d = ARM_LOAD;
        end
      end
      ARM: begin
        if (!en) begin
          state_d = IDLE;
        end else if (arm_cnt_q <= 8'd1) begin
          state_d = CHECK;
        end else begin
          arm_cnt_d = arm_cnt_q - 8'd1;
        end
      end
      CHECK: begin
        if (!en) begin
          state_d = IDLE;
        end else if (eval_fail && (STOP_ON_FAIL != 0)) begin
          state_d = HALT;
        end
      end
      default: state_d = HALT;
    endcase

    // Clear wipes results and the FSM but leaves the timestamp running.
    if (clr) begin
      state_d         = IDLE;
      arm_cnt_d       = 8'd0;
      pass_cnt_d      = '0;
      fail_cnt_d      = '0;
      err_d           = 1'b0;
      first_fail_ts_d = '0;
      pass_pulse_d    = 1'b0;
      fail_pulse_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      arm_cnt_q       <= 8'd0;
      ts_q            <= '0;
      pass_cnt_q      <= '0;
      fail_cnt_q      <= '0;
      err_q           <= 1'b0;
      first_fail_ts_q <= '0;
      pass_pulse_q    <= 1'b0;
      fail_pulse_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      arm_cnt_q       <= arm_cnt_d;
      ts_q            <= ts_d;
      pass_cnt_q      <= pass_cnt_d;
      fail_cnt_q      <= fail_cnt_d;
      err_q           <= err_d;
      first_fail_ts_q <= first_fail_ts_d;
      pass_pulse_q    <= pass_pulse_d;
      fail_pulse_q    <= fail_pulse_d;
    end
  end

  assign pass_pulse    = pass_pulse_q;
  assign fail_pulse    = fail_pulse_q;
  assign pass_cnt      = pass_cnt_q;
  assign fail_cnt      = fail_cnt_q;
  assign err           = err_q;
  assign first_fail_ts = first_fail_ts_q;
  assign state         = state_q;

endmodule

// File: tb/tb_ab_and_monitor.sv
// Directed bench for ab_and_monitor: a vector table on the default build plus
// short sequences on STOP_ON_FAIL, narrow-counter and ARM_CYC=0/3 builds sharing the same inputs.
module tb_ab_and_monitor;

  logic clk;
  logic rst, clr, en, a, b;

  int checks;
  int errors;

  // Default build: CNT_W=16, TS_W=32, ARM_CYC=1, STOP_ON_FAIL=0
  logic        d0_pp, d0_fp, d0_err;
  logic [15:0] d0_pc, d0_fc;
  logic [31:0] d0_ffts;
  logic [1:0]  d0_state;

  // STOP_ON_FAIL=1 build
  logic        dh_pp, dh_fp, dh_err;
  logic [15:0] dh_pc, dh_fc;
  logic [31:0] dh_ffts;
  logic [1:0]  dh_state;

  // CNT_W=4 build
  logic        ds_pp, ds_fp, ds_err;
  logic [3:0]  ds_pc, ds_fc;
  logic [31:0] ds_ffts;
  logic [1:0]  ds_state;

  // ARM_CYC=3 build
  logic        d3_pp, d3_fp, d3_err;
  logic [15:0] d3_pc, d3_fc;
  logic [31:0] d3_ffts;
  logic [1:0]  d3_state;

  // ARM_CYC=0 build
  logic        dz_pp, dz_fp, dz_err;
  logic [15:0] dz_pc, dz_fc;
  logic [31:0] dz_ffts;
  logic [1:0]  dz_state;

  ab_and_monitor dut0 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr(clr),
    .pass_pulse(d0_pp), .fail_pulse(d0_fp), .pass_cnt(d0_pc), .fail_cnt(d0_fc),
    .err(d0_err), .first_fail_ts(d0_ffts), .state(d0_state)
  );

  ab_and_monitor #(.STOP_ON_FAIL(1)) dut_halt (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr(clr),
    .pass_pulse(dh_pp), .fail_pulse(dh_fp), .pass_cnt(dh_pc), .fail_cnt(dh_fc),
    .err(dh_err), .first_fail_ts(dh_ffts), .state(dh_state)
  );

  ab_and_monitor #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr(clr),
    .pass_pulse(ds_pp), .fail_pulse(ds_fp), .pass_cnt(ds_pc), .fail_cnt(ds_fc),
    .err(ds_err), .first_fail_ts(ds_ffts), .state(ds_state)
  );

  ab_and_monitor #(.ARM_CYC(3)) dut_arm3 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr(clr),
    .pass_pulse(d3_pp), .fail_pulse(d3_fp), .pass_cnt(d3_pc), .fail_cnt(d3_fc),
    .err(d3_err), .first_fail_ts(d3_ffts), .state(d3_state)
  );

  ab_and_monitor #(.ARM_CYC(0)) dut_arm0 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clr(clr),
    .pass_pulse(dz_pp), .fail_pulse(dz_fp), .pass_cnt(dz_pc), .fail_cnt(dz_fc),
    .err(dz_err), .first_fail_ts(dz_ffts), .state(dz_state)
  );

  typedef struct {
    logic        rst, clr, en, a, b;
    logic [1:0]  st;
    logic        pp, fp;
    logic [15:0] pc, fc;
    logic        er;
    logic [31:0] ffts;
  } vec_t;

  vec_t vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic applyStimulus(input logic r, input logic c, input logic e,
                               input logic ia, input logic ib);
    @(negedge clk);
    rst = r;
    clr = c;
    en  = e;
    a   = ia;
    b   = ib;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clr = 1'b0;
    en  = 1'b0;
    a   = 1'b0;
    b   = 1'b0;

    // rst clr en a b | state pp fp pass fail err first_fail_ts
    vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0, 2'd0,1'b0,1'b0,16'd0,16'd0,1'b0,32'd0});
    vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0, 2'd0,1'b0,1'b0,16'd0,16'd0,1'b0,32'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1, 2'd1,1'b0,1'b0,16'd0,16'd0,1'b0,32'd0});  // ts=0
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1, 2'd2,1'b0,1'b0,16'd0,16'd0,1'b0,32'd0});  // ts=1
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1, 2'd2,1'b1,1'b0,16'd1,16'd0,1'b0,32'd0});  // ts=2
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1, 2'd2,1'b1,1'b0,16'd2,16'd0,1'b0,32'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1, 2'd2,1'b1,1'b0,16'd3,16'd0,1'b0,32'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1, 2'd2,1'b1,1'b0,16'd4,16'd0,1'b0,32'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1, 2'd2,1'b1,1'b0,16'd5,16'd0,1'b0,32'd0});  // ts=6
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0, 2'd2,1'b0,1'b1,16'd5,16'd1,1'b1,32'd7});  // ts=7
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1, 2'd2,1'b1,1'b0,16'd6,16'd1,1'b1,32'd7});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0, 2'd2,1'b0,1'b1,16'd6,16'd2,1'b1,32'd7});  // ts=9
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1, 2'd2,1'b1,1'b0,16'd7,16'd2,1'b1,32'd7});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,1'b0,1'b0,16'd7,16'd2,1'b1,32'd7});  // en drop
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,1'b0,1'b0,16'd7,16'd2,1'b1,32'd7});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,1'b0,1'b0,16'd7,16'd2,1'b1,32'd7});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 2'd1,1'b0,1'b0,16'd7,16'd2,1'b1,32'd7});  // re-arm
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 2'd2,1'b0,1'b0,16'd7,16'd2,1'b1,32'd7});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b1, 2'd2,1'b0,1'b1,16'd7,16'd3,1'b1,32'd7});  // ts=16
    vecs.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0, 2'd0,1'b0,1'b0,16'd0,16'd0,1'b0,32'd0});  // clr + fail
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1, 2'd1,1'b0,1'b0,16'd0,16'd0,1'b0,32'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1, 2'd2,1'b0,1'b0,16'd0,16'd0,1'b0,32'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0, 2'd2,1'b0,1'b1,16'd0,16'd1,1'b1,32'd20}); // ts=20
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b1, 2'd2,1'b0,1'b1,16'd0,16'd2,1'b1,32'd20});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 2'd2,1'b0,1'b1,16'd0,16'd3,1'b1,32'd20});
    vecs.push_back('{1'b1,1'b0,1'b1,1'b0,1'b0, 2'd0,1'b0,1'b0,16'd0,16'd0,1'b0,32'd0});  // rst in CHECK
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,1'b0,1'b0,16'd0,16'd0,1'b0,32'd0});  // ts=0
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 2'd1,1'b0,1'b0,16'd0,16'd0,1'b0,32'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 2'd2,1'b0,1'b0,16'd0,16'd0,1'b0,32'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 2'd2,1'b0,1'b1,16'd0,16'd1,1'b1,32'd3});  // ts=3

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].en, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("v%0d state", i), 32'(d0_state), 32'(vecs[i].st));
      checkOutput($sformatf("v%0d pass_pulse", i), 32'(d0_pp), 32'(vecs[i].pp));
      checkOutput($sformatf("v%0d fail_pulse", i), 32'(d0_fp), 32'(vecs[i].fp));
      checkOutput($sformatf("v%0d pass_cnt", i), 32'(d0_pc), 32'(vecs[i].pc));
      checkOutput($sformatf("v%0d fail_cnt", i), 32'(d0_fc), 32'(vecs[i].fc));
      checkOutput($sformatf("v%0d err", i), 32'(d0_err), 32'(vecs[i].er));
      checkOutput($sformatf("v%0d first_fail_ts", i), d0_ffts, vecs[i].ffts);
    end

    // STOP_ON_FAIL: failure at ts=4 halts, later passes are ignored, clr recovers.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("halt pass_cnt before fail", 32'(dh_pc), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("halt state", 32'(dh_state), 32'd3);
    checkOutput("halt fail_pulse", 32'(dh_fp), 32'd1);
    checkOutput("halt fail_cnt", 32'(dh_fc), 32'd1);
    checkOutput("halt err", 32'(dh_err), 32'd1);
    checkOutput("halt first_fail_ts", dh_ffts, 32'd4);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput($sformatf("halt hold%0d pass_pulse", i), 32'(dh_pp), 32'd0);
      checkOutput($sformatf("halt hold%0d state", i), 32'(dh_state), 32'd3);
    end
    checkOutput("halt pass_cnt held", 32'(dh_pc), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("halt clr state", 32'(dh_state), 32'd0);
    checkOutput("halt clr pass_cnt", 32'(dh_pc), 32'd0);
    checkOutput("halt clr fail_cnt", 32'(dh_fc), 32'd0);
    checkOutput("halt clr err", 32'(dh_err), 32'd0);
    checkOutput("halt clr first_fail_ts", dh_ffts, 32'd0);

    // CNT_W=4: 20 passing evaluations saturate at 15.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("sat state check", 32'(ds_state), 32'd2);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput($sformatf("sat eval%0d pass_cnt", i), 32'(ds_pc),
                  (i > 15) ? 32'd15 : 32'(i));
    end
    checkOutput("sat pass_pulse", 32'(ds_pp), 32'd1);
    checkOutput("sat fail_cnt", 32'(ds_fc), 32'd0);

    // ARM_CYC=3 arms for three edges; ARM_CYC=0 goes straight to CHECK.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("arm3 entry state", 32'(d3_state), 32'd1);
    checkOutput("arm0 entry state", 32'(dz_state), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("arm0 first pass_cnt", 32'(dz_pc), 32'd1);
    checkOutput("arm3 arm edge1 state", 32'(d3_state), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("arm3 arm edge2 state", 32'(d3_state), 32'd1);
    checkOutput("arm3 no early pass", 32'(d3_pc), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("arm3 arm edge3 state", 32'(d3_state), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("arm3 first pass_pulse", 32'(d3_pp), 32'd1);
    checkOutput("arm3 first pass_cnt", 32'(d3_pc), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("arm3 en drop state", 32'(d3_state), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("arm3 rearm state", 32'(d3_state), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("arm3 rearm hold state", 32'(d3_state), 32'd1);
    checkOutput("arm3 rearm no fail", 32'(d3_fc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ab_and_monitor.md
AB_AND_MONITOR -- requirements
Module: ab_and_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the pass and fail counters.
REQ-002 SHALL have parameter TS_W, default 32, giving the width of the cycle timestamp.
REQ-003 SHALL have parameter ARM_CYC, default 1, giving the number of enabled settle cycles skipped before checking starts (range 0..255).
REQ-004 SHALL have parameter STOP_ON_FAIL, default 0; when 1, the first failure halts checking.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic uses the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port en, input, 1 bit: check enable; low acts as the disable-iff condition.
REQ-008 SHALL have port a, input, 1 bit: first operand under check.
REQ-009 SHALL have port b, input, 1 bit: second operand under check.
REQ-010 SHALL have port clr, input, 1 bit: synchronous clear of results and the state machine.
REQ-011 SHALL have port pass_pulse, output, 1 bit: one-cycle pulse meaning "evaluation passed".
REQ-012 SHALL have port fail_pulse, output, 1 bit: one-cycle pulse meaning "evaluation failed".
REQ-013 SHALL have port pass_cnt, output, CNT_W bits: saturating count of passes.
REQ-014 SHALL have port fail_cnt, output, CNT_W bits: saturating count of failures.
REQ-015 SHALL have port err, output, 1 bit: sticky flag, set on any failure.
REQ-016 SHALL have port first_fail_ts, output, TS_W bits: timestamp of the first failure.
REQ-017 SHALL have port state, output, 2 bits: state encoding, IDLE=0, ARM=1, CHECK=2, HALT=3.

Function
REQ-018 SHALL keep a free-running TS_W timestamp counter ts: ts=0 after a reset edge, +1 on every non-reset edge, wrapping at 2^TS_W-1 to 0.
REQ-019 SHALL apply the following transitions at each non-reset edge, with clr taking priority over all of them:
- IDLE -> ARM when en=1 and ARM_CYC>0.
- IDLE -> CHECK when en=1 and ARM_CYC=0.
- ARM -> CHECK after ARM_CYC consecutive edges in ARM with en=1; an internal 8-bit arm counter is reloaded on entry to ARM.
- ARM or CHECK -> IDLE when en=0, with no evaluation performed.
- CHECK -> HALT on a failure when STOP_ON_FAIL=1.
- HALT holds until clr or rst.
REQ-020 SHALL perform an evaluation only at an edge where state==CHECK, en=1 and clr=0; the result is pass if (a AND b)=1, otherwise fail.
REQ-021 SHALL register the result, so that pass_pulse or fail_pulse is high for exactly the one cycle following the evaluating edge, and both pulses are never high together.
REQ-022 SHALL update pass_cnt/fail_cnt at the evaluating edge, with the value visible in the same cycle as the pulse; the counters saturate at 2^CNT_W-1 and never wrap.
REQ-023 SHALL set err at the first failing edge and hold it high until clr or rst.
REQ-024 SHALL capture the pre-increment ts value of the failing edge into first_fail_ts on the first failure only, leaving it unchanged by later failures.
REQ-025 SHALL, on clr=1 at an edge, zero pass_cnt, fail_cnt, err, first_fail_ts and both pulses, set state to IDLE and discard that edge's sample; ts is not cleared by clr.
REQ-026 SHALL, when clr and a failing sample coincide, apply clr only: no count, no err, no capture.
REQ-027 SHALL treat an en drop in CHECK as discarding that edge's sample; re-enabling restarts the ARM phase.
REQ-028 SHALL ignore a and b in the IDLE, ARM and HALT states.

Reset
REQ-029 SHALL, at an edge with rst=1, force state=IDLE, ts=0, pass_cnt=0, fail_cnt=0, err=0, first_fail_ts=0, pass_pulse=0, fail_pulse=0 and the arm counter to 0, regardless of en or clr.
REQ-030 SHALL abort any ARM, CHECK or HALT activity when rst is asserted mid-operation, with no evaluation at that edge and outputs at their reset values from the next cycle.

Verification
REQ-031 SHALL be verified with ARM_CYC=1: rst for 2 edges, en=1 from ts=0, a=b=1 held -> state IDLE->ARM->CHECK; first pass_pulse follows the edge at ts=2; pass_cnt=5 after 5 evaluations; fail_cnt=0; err=0.
REQ-032 SHALL be verified with a=1, b=0 at the evaluating edge with ts=7, then b=0 again at ts=9 -> fail_pulse twice; fail_cnt=2; err=1; first_fail_ts=7.
REQ-033 SHALL be verified with STOP_ON_FAIL=1 and a failure at ts=4 -> state=HALT; subsequent a=b=1 for 10 cycles leaves pass_cnt unchanged; clr -> state=IDLE, counters 0, err=0.
REQ-034 SHALL be verified with CNT_W=4 and 20 passing evaluations -> pass_cnt saturates at 15 and stays at 15.
REQ-035 SHALL be verified with en=0 for 3 edges while in CHECK with a=0 -> no fail_pulse, state=IDLE, and re-enable repeats the full ARM phase; a separate case with clr and a failing sample at the same edge -> fail_cnt=0 and err=0.
REQ-036 SHALL be verified with rst asserted for 1 edge while in CHECK with fail_cnt=3 -> all outputs at reset values; ts restarts from 0.
